// File: rtl/pow_5_pkg.sv
// Shared types, defaults and round-robin pick helper for the pow_5 scheduler.
package pow_5_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned ID_W_DEFAULT  = $clog2(N_REQ_DEFAULT);

  // Upper bound on requesters; rr_pick works on vectors of this size.
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;
  localparam int unsigned CAND_W   = MAX_ID_W + 1;

  // One pipeline stage record for the default configuration.
  typedef struct packed {
    logic                    vld;
    logic [W_DEFAULT-1:0]    arg;
    logic [W_DEFAULT-1:0]    acc;
    logic [ID_W_DEFAULT-1:0] id;
  } stage_t;

  // Result of a round-robin search.
  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } pick_t;

  // First set bit of vld_vec searching ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  vld_vec,
                                    input logic [MAX_ID_W-1:0] ptr,
                                    input int unsigned         n);
    pick_t             p;
    logic [CAND_W-1:0] cand;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = CAND_W'(ptr) + CAND_W'(k);
      if (cand >= CAND_W'(n)) cand = cand - CAND_W'(n);
      if (!p.found && (k < n) && vld_vec[cand[MAX_ID_W-1:0]]) begin
        p.found = 1'b1;
        p.idx   = cand[MAX_ID_W-1:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pow_5_tag_pipe.sv
// Five-stage tagged x^5 datapath; all stages advance together under en.
module pow_5_tag_pipe
  import pow_5_pkg::*;
#(
  parameter int unsigned W    = W_DEFAULT,
  parameter int unsigned ID_W = ID_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            ld_vld,
  input  logic [W-1:0]    ld_arg,
  input  logic [ID_W-1:0] ld_id,
  output logic            out_vld,
  output logic [W-1:0]    out_acc,
  output logic [ID_W-1:0] out_id
);

  // S1..S4 carry the argument; S5 only needs the finished product.
  localparam int unsigned N_MID = 4;

  typedef struct packed {
    logic            vld;
    logic [W-1:0]    arg;
    logic [W-1:0]    acc;
    logic [ID_W-1:0] id;
  } tag_stage_t;

  tag_stage_t stg [N_MID];

  // Shift the pipe one step per enabled cycle, multiplying acc by arg each step.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int j = 0; j < N_MID; j++) stg[j] <= '0;
      out_vld <= 1'b0;
      out_acc <= '0;
      out_id  <= '0;
    end else if (en) begin
      stg[0] <= '{vld: ld_vld, arg: ld_arg, acc: ld_arg, id: ld_id};
      for (int j = 1; j < N_MID; j++) begin
        stg[j].vld <= stg[j-1].vld;
        stg[j].arg <= stg[j-1].arg;
        stg[j].acc <= W'(stg[j-1].acc * stg[j-1].arg);
        stg[j].id  <= stg[j-1].id;
      end
      out_vld <= stg[N_MID-1].vld;
      out_acc <= W'(stg[N_MID-1].acc * stg[N_MID-1].arg);
      out_id  <= stg[N_MID-1].id;
    end
  end

endmodule

// File: rtl/pow_5_rr_sched.sv
// Round-robin front end sharing one pow_5 pipeline among N_REQ requesters.
module pow_5_rr_sched
  import pow_5_pkg::*;
#(
  parameter  int unsigned W     = W_DEFAULT,
  parameter  int unsigned N_REQ = N_REQ_DEFAULT,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_vld,
  input  logic [N_REQ*W-1:0] req_arg,
  output logic [N_REQ-1:0]   req_rdy,
  output logic               res_vld,
  output logic [W-1:0]       res,
  output logic [ID_W-1:0]    res_id,
  input  logic               res_rdy
);

  logic [ID_W-1:0] ptr;
  logic            en_c;
  logic            acc_c;
  pick_t           pick_c;
  logic [ID_W-1:0] sel_id_c;
  logic [W-1:0]    sel_arg_c;

  // Pipeline advances unless a result is waiting on a stalled consumer.
  assign en_c = !res_vld || res_rdy;

  // Pick the next requester from ptr, raise its ready and mux its argument.
  always_comb begin
    req_rdy   = '0;
    sel_arg_c = '0;
    pick_c    = rr_pick(MAX_REQ'(req_vld), MAX_ID_W'(ptr), N_REQ);
    sel_id_c  = ID_W'(pick_c.idx);
    acc_c     = pick_c.found && en_c && !rst_n;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == sel_id_c) begin
        sel_arg_c  = req_arg[i*W +: W];
        req_rdy[i] = acc_c;
      end
    end
  end

  // Move the search start just past the requester that was served.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ptr <= '0;
    end else if (acc_c) begin
      ptr <= (sel_id_c == ID_W'(N_REQ - 1)) ? '0 : sel_id_c + ID_W'(1);
    end
  end

  pow_5_tag_pipe #(
    .W    (W),
    .ID_W (ID_W)
  ) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en_c),
    .ld_vld  (acc_c),
    .ld_arg  (sel_arg_c),
    .ld_id   (sel_id_c),
    .out_vld (res_vld),
    .out_acc (res),
    .out_id  (res_id)
  );

endmodule

// File: tb/tb_pow_5_rr_sched.sv
// Scoreboard bench for pow_5_rr_sched: models arbitration, latency and x^5 results.
module tb_pow_5_rr_sched;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_vld;
  logic [N*W-1:0] req_arg;
  logic [N-1:0]   req_rdy;
  logic           res_vld;
  logic [W-1:0]   res;
  logic [1:0]     res_id;
  logic           res_rdy;

  pow_5_rr_sched #(.W(W), .N_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_vld (req_vld),
    .req_arg (req_arg),
    .req_rdy (req_rdy),
    .res_vld (res_vld),
    .res     (res),
    .res_id  (res_id),
    .res_rdy (res_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int val;
    int due;
  } exp_t;

  exp_t   sb [$];
  int     pop_res [$];
  int     pop_id  [$];
  int     n_chk = 0;
  int     n_bad = 0;
  int     cyc   = 0;
  int     mptr  = 0;
  int     acc_cnt = 0;
  bit [N-1:0] pend_vld = '0;
  int     pend_arg [N];
  bit     rdy_q = 1'b1;
  bit     rst_q = 1'b1;
  bit     hold_prev = 1'b0;
  int     prev_res = 0;
  int     prev_id  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pow5(input int a);
    longint unsigned p;
    p = longint'(a);
    p = p * p * p * p * p;
    return int'(p & 64'd255);
  endfunction

  // One clock: drive, compare against the model, advance the model, clock.
  task automatic step();
    int   g;
    int   idx;
    bit   en;
    bit   exp_vld;
    int   exp_rdy;
    exp_t e;
    req_vld = pend_vld;
    for (int i = 0; i < N; i++) req_arg[i*W +: W] = 8'(pend_arg[i]);
    res_rdy = rdy_q;
    rst_n   = rst_q;
    #1;
    if (rst_q) begin
      sb.delete();
      mptr      = 0;
      hold_prev = 1'b0;
      chk("rst_vld", int'(res_vld), 0);
      chk("rst_res", int'(res), 0);
      chk("rst_id",  int'(res_id), 0);
      chk("rst_rdy", int'(req_rdy), 0);
    end else begin
      exp_vld = (sb.size() > 0) && (sb[0].due <= cyc);
      chk("res_vld", int'(res_vld), int'(exp_vld));
      if (hold_prev) begin
        chk("hold_res", int'(res), prev_res);
        chk("hold_id",  int'(res_id), prev_id);
      end
      en = !exp_vld || rdy_q;
      g  = -1;
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && pend_vld[idx]) g = idx;
      end
      exp_rdy = (en && g >= 0) ? (1 << g) : 0;
      chk("req_rdy", int'(req_rdy), exp_rdy);
      if (exp_vld && rdy_q) begin
        e = sb.pop_front();
        chk("res", int'(res), e.val);
        chk("res_id", int'(res_id), e.id);
        pop_res.push_back(int'(res));
        pop_id.push_back(int'(res_id));
      end
      if (!en) begin
        foreach (sb[j]) if (sb[j].due > cyc) sb[j].due = sb[j].due + 1;
      end
      if (en && g >= 0) begin
        e.id  = g;
        e.val = pow5(pend_arg[g]);
        e.due = cyc + 5;
        sb.push_back(e);
        mptr        = (g + 1) % N;
        pend_vld[g] = 1'b0;
        acc_cnt++;
      end
      hold_prev = exp_vld && !rdy_q;
      prev_res  = int'(res);
      prev_id   = int'(res_id);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    pend_vld = '0;
    rdy_q    = 1'b1;
    for (int k = 0; k < 40 && sb.size() > 0; k++) step();
    chk(tag, sb.size(), 0);
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_w [4];
    int base;
    int n_acc0;
    exp_w = '{0, 167, 53, 255};
    req_vld = '0;
    req_arg = '0;
    res_rdy = 1'b1;
    rst_n   = 1'b1;
    for (int i = 0; i < N; i++) pend_arg[i] = 0;
    @(negedge clk);

    // Reset with a requester asking: nothing granted, outputs zero.
    rst_q = 1'b1;
    pend_vld[0] = 1'b1;
    pend_arg[0] = 9;
    repeat (3) step();
    rst_q = 1'b0;
    pend_vld = '0;
    step();

    // Single issue: 3^5 = 243 from requester 1.
    pop_res.delete(); pop_id.delete();
    pend_vld[1] = 1'b1;
    pend_arg[1] = 3;
    step();
    repeat (6) step();
    chk("single_cnt", pop_res.size(), 1);
    if (pop_res.size() > 0) begin
      chk("single_res", pop_res[0], 243);
      chk("single_id", pop_id[0], 1);
    end

    // Back-to-back wrap arithmetic from requester 0.
    pop_res.delete(); pop_id.delete();
    foreach (exp_w[i]) begin
      pend_vld[0] = 1'b1;
      pend_arg[0] = (i == 0) ? 4 : (i == 1) ? 7 : (i == 2) ? 5 : 255;
      step();
    end
    drain("wrap_drain");
    chk("wrap_cnt", pop_res.size(), 4);
    for (int i = 0; i < 4 && i < pop_res.size(); i++) begin
      chk("wrap_res", pop_res[i], exp_w[i]);
      chk("wrap_id", pop_id[i], 0);
    end

    // Reset with three items in flight, then first grant from index 0.
    for (int i = 0; i < 3; i++) begin
      pend_vld[i] = 1'b1;
      pend_arg[i] = 10 + i;
    end
    repeat (3) step();
    rst_q = 1'b1;
    pend_vld = 4'b1010;
    pend_arg[1] = 6;
    pend_arg[3] = 200;
    repeat (2) step();
    rst_q = 1'b0;
    pop_res.delete(); pop_id.delete();
    repeat (2) step();
    drain("rst_drain");
    chk("rst_cnt", pop_res.size(), 2);
    if (pop_id.size() > 1) begin
      chk("rst_first_id", pop_id[0], 1);
      chk("rst_first_res", pop_res[0], 96);
      chk("rst_second_id", pop_id[1], 3);
    end

    // Fairness: all four requesting, arg = index + 2.
    pop_res.delete(); pop_id.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        pend_vld[i] = 1'b1;
        pend_arg[i] = i + 2;
      end
      step();
    end
    drain("fair_drain");
    chk("fair_cnt", pop_id.size(), 12);
    for (int j = 0; j < pop_id.size(); j++) begin
      chk("fair_id", pop_id[j], j % 4);
      if (pop_id[j] == 0) chk("fair_r0", pop_res[j], 32);
      if (pop_id[j] == 1) chk("fair_r1", pop_res[j], 243);
    end

    // Backpressure: stall the output for several cycles with a full pipe.
    pop_res.delete(); pop_id.delete();
    n_acc0 = acc_cnt;
    rdy_q  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      pend_vld[2] = 1'b1; pend_arg[2] = 20 + c;
      pend_vld[3] = 1'b1; pend_arg[3] = 40 + c;
      step();
    end
    rdy_q = 1'b0;
    for (int c = 0; c < 7; c++) begin
      pend_vld[2] = 1'b1; pend_arg[2] = 60 + c;
      step();
    end
    base = acc_cnt - n_acc0;
    drain("bp_drain");
    chk("bp_cnt", pop_res.size(), base);

    // Randomised stress.
    pop_res.delete(); pop_id.delete();
    n_acc0 = acc_cnt;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_vld[i] && $urandom_range(0, 1) == 1) begin
          pend_vld[i] = 1'b1;
          pend_arg[i] = int'($urandom_range(0, 255));
        end
      end
      rdy_q = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("stress_drain");
    chk("stress_cnt", pop_res.size(), acc_cnt - n_acc0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pow_5_rr_sched.md
# pow_5_rr_sched

Round-robin scheduler that shares one pipelined x^5 datapath (W-bit, modulo 2^W) between N_REQ requesters. It accepts at most one argument per cycle over per-requester valid/ready handshakes and tags each issued argument with its requester index. It returns the result with that tag on a single output channel with backpressure. It sits between several power-computing clients and a single shared pow_5 pipeline.

## Interface
- W, 8, argument/result width in bits
- N_REQ, 4, number of requesters (2..16); ID_W = $clog2(N_REQ) is a derived localparam
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, asynchronous, active-high (rst_n = 1 resets)
- req_vld  in  N_REQ  per-requester argument valid
- req_arg  in  N_REQ*W  packed arguments; requester i on bits [i*W +: W]
- req_rdy  out  N_REQ  per-requester ready; at most one bit set (one-hot grant)
- res_vld  out  1  result valid
- res  out  W  arg^5 mod 2^W
- res_id  out  ID_W  index of the requester that issued the result
- res_rdy  in  1  downstream ready

## Operation
- Datapath: 5 register stages S1..S5, each holding {vld, arg, acc, id}.
  - Issue: S1.acc = arg.
  - Stage step: S(j+1).acc = S(j).acc * S(j).arg, truncated to W bits; arg and id travel unchanged.
  - S5 holds arg^5. The outputs are res_vld = S5.vld, res = S5.acc, res_id = S5.id.
- Global enable: en = !S5.vld || res_rdy. When en = 0, every stage holds its value and no request is accepted. Bubbles are not collapsed.
- Arbitration:
  - A round-robin pointer ptr (ID_W bits, reset 0) sets the search start.
  - The grant goes to the first i with req_vld[i] = 1, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - req_rdy[i] = en && grant[i] && !reset.
- Accept: req_vld[i] && req_rdy[i] at a rising edge. S1 loads {1, req_arg[i], req_arg[i], i} and ptr becomes (i+1) mod N_REQ.
- No accept while en = 1: S1.vld becomes 0 and ptr holds.
- Output handshake: res_vld && res_rdy at an edge consumes the result.
- req_rdy depends combinationally on req_vld. Requesters must not make req_vld depend on req_rdy.
- Once raised, req_vld and req_arg stay stable until accepted. The bench checks this; the block does not.
- Arithmetic: all products are unsigned and wrap modulo 2^W. No overflow flag.

## Timing
- Reset (rst_n = 1):
  - All stage vld, acc, arg and id cleared, ptr = 0.
  - Outputs: res_vld = 0, res = 0, res_id = 0, req_rdy = 0.
  - Reset mid-operation discards every in-flight item without producing output.
- Latency: an argument accepted at edge k has res_vld = 1 after edge k+4, provided en stays 1. A stall adds one cycle per cycle with en = 0.
- Throughput: one result per cycle while res_rdy = 1 and any req_vld is high.
- Backpressure: when res_vld = 1 and res_rdy = 0, the pipeline freezes and req_rdy = 0. res, res_id and res_vld hold stable until consumed.
- Consume and issue in the same edge: allowed (en = 1); S5 takes S4's content.
- Wrap-around:
  - ptr = N_REQ-1 wraps to 0 after a grant to N_REQ-1.
  - If N_REQ is not a power of two, ptr never takes values ≥ N_REQ.
- A single active requester is granted every cycle. All N_REQ active means each is granted exactly once per N_REQ accepts.

## Structure
- The shared package pow_5_pkg holds:
  - the stage record typedef {vld, arg, acc, id}, parameterised through package localparams W_DEFAULT and N_REQ_DEFAULT
  - the function rr_pick(vld_vec, ptr) returning the grant index and a found bit
- Sub-module pow_5_tag_pipe holds the 5-stage tagged datapath with input en, the S1 load port and the S5 output.
- pow_5_rr_sched holds the arbiter, ptr and the enable logic, and instantiates pow_5_tag_pipe.

## Test plan
- Single issue (W=8): req 1 presents 3 once, res_rdy = 1 → after edge k+4, res_vld = 1, res = 243, res_id = 1, for exactly one cycle.
- Wrap arithmetic: args 4, 7, 5, 255 back-to-back from req 0 → res 0, 167, 53, 255 on consecutive cycles, all with res_id = 0.
- Fairness: all four req_vld held high, each arg = its index + 2 → res_id sequence 0,1,2,3,0,1,...; req 0 results = 32, req 1 results = 243.
- Backpressure: res_rdy = 0 for 6 cycles while res_vld = 1 → res, res_id and res_vld stable, req_rdy = 0. Release res_rdy → remaining results arrive in order with none lost or duplicated.
- Reset mid-flight: assert rst_n with 3 items in the pipe → res_vld = 0 the same cycle, ptr = 0. After release, no stale result appears and the first grant goes to the lowest active index.
- Randomised stress: random req_vld and res_rdy for 2000 cycles, scoreboard per requester → every accepted arg returns arg^5 mod 256 with the correct id, in issue order.
